dest_reg_pipe: RTL

//   Parametrised successor to the 2:1 rt/rd destination mux. Selects the write-back register index (rt, rd, link or none).

---
 rtl/dest_reg_pkg.sv | 16 +
 rtl/dest_stage.sv | 33 +++
 rtl/dest_reg_pipe.sv | 119 +++++++++++
 3 files changed

// File: rtl/dest_reg_pkg.sv
// Shared encodings and defaults for the destination-register pipeline.
package dest_reg_pkg;

  typedef logic [1:0] dst_mode_t;

  // Destination select encodings
  localparam dst_mode_t DST_RT   = 2'b00;
  localparam dst_mode_t DST_RD   = 2'b01;
  localparam dst_mode_t DST_LINK = 2'b10;
  localparam dst_mode_t DST_NONE = 2'b11;

  // Default geometry
  localparam int unsigned REG_W_DEF    = 3;
  localparam int unsigned LINK_REG_DEF = 7;

endpackage

// File: rtl/dest_stage.sv
// One pipeline slot: valid bit plus destination index.
//   clear : empty the slot (highest priority)
//   load  : take d_vld/d_reg; otherwise the slot holds
// The index is forced to zero whenever the loaded valid bit is low, so an
// empty slot never shows a stale index.
module dest_stage #(
  parameter int unsigned REG_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic             d_vld,
  input  logic [REG_W-1:0] d_reg,
  output logic             q_vld,
  output logic [REG_W-1:0] q_reg
);

  // Slot register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_vld <= 1'b0;
      q_reg <= '0;
    end else if (clear) begin
      q_vld <= 1'b0;
      q_reg <= '0;
    end else if (load) begin
      q_vld <= d_vld;
      q_reg <= d_vld ? d_reg : '0;
    end
  end

endmodule

// File: rtl/dest_reg_pipe.sv
// Destination-register pipeline: selects the write-back index (rt/rd/link/
// none), carries it with a valid bit through DEPTH stages with stall and
// flush, and reports source hazards with the youngest matching stage.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid, rt, rd     decode slot and its register fields
//   dst_mode             00 RT, 01 RD, 10 LINK, 11 NONE
//   stall, flush         freeze all stages / kill capture and stage 0
//   src_a, src_b         source indices under test
//   hazard_*, fwd_*      match flag and youngest matching stage (comb)
//   stage_vld, stage_reg per-stage contents, index 0 = youngest
//   wb_valid, wb_reg     oldest stage (write-back)
module dest_reg_pipe
  import dest_reg_pkg::*;
#(
  parameter int unsigned REG_W    = REG_W_DEF,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned LINK_REG = LINK_REG_DEF,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned FWD_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [REG_W-1:0]       rt,
  input  logic [REG_W-1:0]       rd,
  input  logic [1:0]             dst_mode,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [REG_W-1:0]       src_a,
  input  logic [REG_W-1:0]       src_b,
  output logic                   hazard_a,
  output logic                   hazard_b,
  output logic [FWD_W-1:0]       fwd_a,
  output logic [FWD_W-1:0]       fwd_b,
  output logic [DEPTH-1:0]       stage_vld,
  output logic [DEPTH*REG_W-1:0] stage_reg,
  output logic                   wb_valid,
  output logic [REG_W-1:0]       wb_reg
);

  logic                        zero_en;
  logic [REG_W-1:0]            sel;
  logic                        cap_vld;
  logic                        adv;
  logic [DEPTH-1:0]            vld_q;
  logic [DEPTH-1:0][REG_W-1:0] reg_q;
  logic [DEPTH-1:0]            match_a;
  logic [DEPTH-1:0]            match_b;

  assign zero_en = (ZERO_REG != 0);

  // Destination select and capture qualification
  always_comb begin
    sel = '0;
    case (dst_mode)
      DST_RT:   sel = rt;
      DST_RD:   sel = rd;
      DST_LINK: sel = REG_W'(LINK_REG);
      default:  sel = '0;
    endcase
    cap_vld = in_valid && (dst_mode != DST_NONE) && !(zero_en && (sel == '0));
  end

  // Flush forces the pipe to move even under stall.
  assign adv = flush || !stall;

  // Stage 0 captures the decode slot; stage 1 takes the killed stage 0 as a
  // bubble on flush, which is why both are cleared together.
  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_stage
    if (i == 0) begin : g_head
      dest_stage #(.REG_W(REG_W)) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .load  (adv),
        .d_vld (cap_vld),
        .d_reg (sel),
        .q_vld (vld_q[i]),
        .q_reg (reg_q[i])
      );
    end else begin : g_body
      dest_stage #(.REG_W(REG_W)) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush && (i == 1)),
        .load  (adv),
        .d_vld (vld_q[i-1]),
        .d_reg (reg_q[i-1]),
        .q_vld (vld_q[i]),
        .q_reg (reg_q[i])
      );
    end
  end

  // Hazard compare; the downward scan leaves the lowest matching stage.
  always_comb begin
    match_a = '0;
    match_b = '0;
    fwd_a   = '0;
    fwd_b   = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      match_a[i] = vld_q[i] && (reg_q[i] == src_a) && !(zero_en && (src_a == '0));
      match_b[i] = vld_q[i] && (reg_q[i] == src_b) && !(zero_en && (src_b == '0));
    end
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (match_a[i]) fwd_a = FWD_W'(i);
      if (match_b[i]) fwd_b = FWD_W'(i);
    end
    hazard_a = |match_a;
    hazard_b = |match_b;
  end

  assign stage_vld = vld_q;
  assign stage_reg = reg_q;
  assign wb_valid  = vld_q[DEPTH-1];
  assign wb_reg    = reg_q[DEPTH-1];

endmodule
